// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    // Pointer width never drops below one bit, even for tiny depths.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read, no reset.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised synchronous FIFO with optional first-word-fall-through output,
// occupancy count, programmable thresholds, sticky error flags and flush.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      rd_en,
    output logic [DATA_WIDTH-1:0]     data_out,
    input  logic                      flush,
    input  logic                      clr_err,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      ovf_sticky,
    output logic                      udf_sticky
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);
    localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  r_ovf_sticky;
    logic                  r_udf_sticky;

    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_ram_we;
    logic                  w_ovf_nxt;
    logic                  w_udf_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic [PW-1:0]         w_wr_ptr_inc;
    logic [PW-1:0]         w_rd_ptr_inc;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Acceptance uses registered flags; a pop frees a slot for a same-cycle write when full.
    assign w_rd_acc    = rd_en && !r_empty;
    assign w_wr_acc    = wr_en && (!r_full || w_rd_acc);
    assign w_ram_we    = w_wr_acc && !flush;
    assign w_ovf_nxt   = !flush && wr_en && !w_wr_acc;
    assign w_udf_nxt   = !flush && rd_en && !w_rd_acc;
    assign w_count_nxt = flush ? '0 : (r_count + CW'(w_wr_acc) - CW'(w_rd_acc));

    assign w_wr_ptr_inc = (r_wr_ptr == P_LAST) ? '0 : (r_wr_ptr + PW'(1));
    assign w_rd_ptr_inc = (r_rd_ptr == P_LAST) ? '0 : (r_rd_ptr + PW'(1));

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PW)
    ) u_ram (
        .clk        (clk),
        .i_wr_en    (w_ram_we),
        .i_wr_addr  (r_wr_ptr),
        .i_wr_data  (data_in),
        .i_rd_addr  (r_rd_ptr),
        .o_rd_data  (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= w_wr_ptr_inc;
            if (w_rd_acc) r_rd_ptr <= w_rd_ptr_inc;
        end
    end

    // Status flags are computed from the next count so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == C_DEPTH);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= C_AF);
            r_aempty <= (w_count_nxt <= C_AE);
        end
    end

    // A new error in the same cycle as clr_err keeps the sticky flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf        <= 1'b0;
            r_udf        <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_udf_sticky <= 1'b0;
        end else begin
            r_ovf <= w_ovf_nxt;
            r_udf <= w_udf_nxt;
            if (w_ovf_nxt)    r_ovf_sticky <= 1'b1;
            else if (clr_err) r_ovf_sticky <= 1'b0;
            if (w_udf_nxt)    r_udf_sticky <= 1'b1;
            else if (clr_err) r_udf_sticky <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = r_empty ? '0 : w_rd_data;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_dout;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dout <= '0;
                end else if (flush) begin
                    r_dout <= '0;
                end else if (w_rd_acc) begin
                    r_dout <= w_rd_data;
                end
            end

            assign data_out = r_dout;
        end
    endgenerate

    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;
    assign ovf_sticky   = r_ovf_sticky;
    assign udf_sticky   = r_udf_sticky;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench: three FIFO flavours (standard 16, FWFT 16, standard 5)
// share one stimulus stream and are compared every cycle against a queue model.
module tb_sync_fifo_flex;

    localparam int DEP [3] = '{16, 16, 5};
    localparam int FW  [3] = '{0, 1, 0};

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic       flush;
    logic       clr_err;
    logic [7:0] data_in;

    logic [7:0] dout   [3];
    logic       fullO  [3];
    logic       emptyO [3];
    logic       afO    [3];
    logic       aeO    [3];
    logic       ovfO   [3];
    logic       udfO   [3];
    logic       ovfS   [3];
    logic       udfS   [3];
    logic [4:0] cntA;
    logic [4:0] cntB;
    logic [2:0] cntC;

    int checks = 0;
    int errors = 0;

    // Reference model state: contents as a plain queue per instance.
    logic [7:0] mq [3][$];
    logic [7:0] mDout [3];
    bit         mOvf  [3];
    bit         mUdf  [3];
    bit         mOvfS [3];
    bit         mUdfS [3];
    int         mN;
    bit         mRacc;
    bit         mWacc;

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout[0]), .flush(flush), .clr_err(clr_err), .full(fullO[0]),
        .empty(emptyO[0]), .almost_full(afO[0]), .almost_empty(aeO[0]), .count(cntA),
        .overflow(ovfO[0]), .underflow(udfO[0]), .ovf_sticky(ovfS[0]), .udf_sticky(udfS[0])
    );

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout[1]), .flush(flush), .clr_err(clr_err), .full(fullO[1]),
        .empty(emptyO[1]), .almost_full(afO[1]), .almost_empty(aeO[1]), .count(cntB),
        .overflow(ovfO[1]), .underflow(udfO[1]), .ovf_sticky(ovfS[1]), .udf_sticky(udfS[1])
    );

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout[2]), .flush(flush), .clr_err(clr_err), .full(fullO[2]),
        .empty(emptyO[2]), .almost_full(afO[2]), .almost_empty(aeO[2]), .count(cntC),
        .overflow(ovfO[2]), .underflow(udfO[2]), .ovf_sticky(ovfS[2]), .udf_sticky(udfS[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actCount(input int k);
        if (k == 0) return 32'(cntA);
        if (k == 1) return 32'(cntB);
        return 32'(cntC);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model step: apply the FIFO rules to the queue at each active edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                mq[k].delete();
                mDout[k] = 8'h00;
                mOvf[k]  = 1'b0;
                mUdf[k]  = 1'b0;
                mOvfS[k] = 1'b0;
                mUdfS[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                mN    = mq[k].size();
                mRacc = rd_en && (mN != 0);
                mWacc = wr_en && ((mN != DEP[k]) || mRacc);
                if (flush) begin
                    mq[k].delete();
                    mDout[k] = 8'h00;
                    mOvf[k]  = 1'b0;
                    mUdf[k]  = 1'b0;
                    if (clr_err) begin
                        mOvfS[k] = 1'b0;
                        mUdfS[k] = 1'b0;
                    end
                end else begin
                    mOvf[k] = wr_en && !mWacc;
                    mUdf[k] = rd_en && !mRacc;
                    if (mRacc) mDout[k] = mq[k].pop_front();
                    if (mWacc) mq[k].push_back(data_in);
                    if (mOvf[k])      mOvfS[k] = 1'b1;
                    else if (clr_err) mOvfS[k] = 1'b0;
                    if (mUdf[k])      mUdfS[k] = 1'b1;
                    else if (clr_err) mUdfS[k] = 1'b0;
                end
            end
        end
    end

    // Compare process: every cycle outside reset, all outputs of all instances.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                automatic int         n  = mq[k].size();
                automatic logic [7:0] eD = (FW[k] != 0) ? ((n != 0) ? mq[k][0] : 8'h00) : mDout[k];
                checkOutput($sformatf("data_out[%0d]", k), 32'(dout[k]), 32'(eD));
                checkOutput($sformatf("count[%0d]", k), actCount(k), 32'(n));
                checkOutput($sformatf("empty[%0d]", k), 32'(emptyO[k]), 32'(n == 0));
                checkOutput($sformatf("full[%0d]", k), 32'(fullO[k]), 32'(n == DEP[k]));
                checkOutput($sformatf("almost_full[%0d]", k), 32'(afO[k]), 32'(n >= DEP[k] - 2));
                checkOutput($sformatf("almost_empty[%0d]", k), 32'(aeO[k]), 32'(n <= 1));
                checkOutput($sformatf("overflow[%0d]", k), 32'(ovfO[k]), 32'(mOvf[k]));
                checkOutput($sformatf("underflow[%0d]", k), 32'(udfO[k]), 32'(mUdf[k]));
                checkOutput($sformatf("ovf_sticky[%0d]", k), 32'(ovfS[k]), 32'(mOvfS[k]));
                checkOutput($sformatf("udf_sticky[%0d]", k), 32'(udfS[k]), 32'(mUdfS[k]));
            end
        end
    end

    // Drive one cycle of inputs at the falling edge, return just after the rising edge.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r,
                                 input logic f, input logic c);
        @(negedge clk);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        flush   = f;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s data_out[%0d]", tag, k), 32'(dout[k]), 32'h0);
            checkOutput($sformatf("%s count[%0d]", tag, k), actCount(k), 32'h0);
            checkOutput($sformatf("%s empty[%0d]", tag, k), 32'(emptyO[k]), 32'h1);
            checkOutput($sformatf("%s full[%0d]", tag, k), 32'(fullO[k]), 32'h0);
            checkOutput($sformatf("%s almost_empty[%0d]", tag, k), 32'(aeO[k]), 32'h1);
            checkOutput($sformatf("%s almost_full[%0d]", tag, k), 32'(afO[k]), 32'h0);
            checkOutput($sformatf("%s overflow[%0d]", tag, k), 32'(ovfO[k]), 32'h0);
            checkOutput($sformatf("%s underflow[%0d]", tag, k), 32'(udfO[k]), 32'h0);
            checkOutput($sformatf("%s ovf_sticky[%0d]", tag, k), 32'(ovfS[k]), 32'h0);
            checkOutput($sformatf("%s udf_sticky[%0d]", tag, k), 32'(udfS[k]), 32'h0);
        end
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = 8'h00;
        #1 rst = 1'b1;
        #1 checkResetState("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] fill 16 words 0x11..0x20");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
            if (i == 12) checkOutput("lit af_at_13", 32'(afO[0]), 32'h0);
            if (i == 13) checkOutput("lit af_at_14", 32'(afO[0]), 32'h1);
        end
        checkOutput("lit full_after_16", 32'(fullO[0]), 32'h1);
        checkOutput("lit count_after_16", actCount(0), 32'd16);
        checkOutput("lit fwft_head", 32'(dout[1]), 32'h11);

        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        checkOutput("lit overflow_pulse", 32'(ovfO[0]), 32'h1);
        checkOutput("lit ovf_sticky_set", 32'(ovfS[0]), 32'h1);
        checkOutput("lit count_after_ovf", actCount(0), 32'd16);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("lit overflow_one_cycle", 32'(ovfO[0]), 32'h0);

        $display("[TB] drain 16 words");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("lit drain_%0d", i), 32'(dout[0]), 32'(8'(8'h11 + i)));
        end
        checkOutput("lit count_drained", actCount(0), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("lit underflow_pulse", 32'(udfO[0]), 32'h1);
        checkOutput("lit udf_sticky_set", 32'(udfS[0]), 32'h1);
        checkOutput("lit dout_holds", 32'(dout[0]), 32'h20);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("lit clr_ovf", 32'(ovfS[0]), 32'h0);
        checkOutput("lit clr_udf", 32'(udfS[0]), 32'h0);

        $display("[TB] full FIFO with simultaneous read and write");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        checkOutput("lit simul_count", actCount(0), 32'd16);
        checkOutput("lit simul_no_ovf", 32'(ovfO[0]), 32'h0);
        checkOutput("lit simul_dout", 32'(dout[0]), 32'h11);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("lit simul_last", 32'(dout[0]), 32'h55);

        $display("[TB] FWFT fall-through");
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        checkOutput("lit fwft_data", 32'(dout[1]), 32'h3C);
        checkOutput("lit fwft_not_empty", 32'(emptyO[1]), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("lit fwft_empty", 32'(emptyO[1]), 32'h1);
        checkOutput("lit fwft_zero", 32'(dout[1]), 32'h0);

        $display("[TB] flush with write pending");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        checkOutput("lit flush_count", actCount(0), 32'd0);
        checkOutput("lit flush_empty", 32'(emptyO[0]), 32'h1);
        checkOutput("lit flush_dout", 32'(dout[0]), 32'h0);
        checkOutput("lit flush_keeps_sticky", 32'(ovfS[2]), 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("lit clr_c_ovf", 32'(ovfS[2]), 32'h0);
        checkOutput("lit clr_c_udf", 32'(udfS[2]), 32'h0);

        $display("[TB] depth 5 wrap");
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 5; j++) applyStimulus(1'b1, 8'(r * 5 + j), 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("lit wrap_full_%0d", r), 32'(fullO[2]), 32'h1);
            for (int j = 0; j < 5; j++) begin
                applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
                checkOutput($sformatf("lit wrap_%0d_%0d", r, j), 32'(dout[2]), 32'(r * 5 + j));
            end
        end

        $display("[TB] asynchronous reset mid-burst");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 checkResetState("midrst");
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
